// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mac_pkg
// Purpose : Shared types and default widths for the MAC datapath.
//           - acc_state_e : accumulator control states
//           - *_WIDTH_DEF : default parameter values for the datapath blocks
// Revision: 1.0 - initial release
// ============================================================================
package mac_pkg;

  // Default widths. A product is twice the multiplier operand width.
  localparam int PROD_WIDTH_DEF = 32;
  localparam int ACC_WIDTH_DEF  = 40;
  localparam int CNT_WIDTH_DEF  = 8;

  // IDLE  : no partial sum held
  // ACCUM : partial sum held, waiting for more terms
  // DONE  : finished result presented on the output port
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/sat_adder.sv
`default_nettype none
// ============================================================================
// Module  : sat_adder
// Purpose : Unsigned ACC_WIDTH adder with carry detection and optional
//           clamp-to-all-ones on carry. Purely combinational.
// Ports   : acc    in  [ACC_WIDTH-1:0] running sum
//           addend in  [ACC_WIDTH-1:0] zero-extended term
//           sum    out [ACC_WIDTH-1:0] clamped or wrapped result
//           carry  out                 carry out of the ACC_WIDTH+1 bit sum
// Revision: 1.0 - initial release
// ============================================================================
module sat_adder #(
  parameter int ACC_WIDTH = 40,
  parameter int SATURATE  = 1
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [ACC_WIDTH-1:0] addend,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 carry
);

  // One extra bit so the carry is captured rather than lost.
  logic [ACC_WIDTH:0] full_sum;

  assign full_sum = {1'b0, acc} + {1'b0, addend};
  assign carry    = full_sum[ACC_WIDTH];

  generate
    if (SATURATE != 0) begin : g_saturate
      assign sum = carry ? {ACC_WIDTH{1'b1}} : full_sum[ACC_WIDTH-1:0];
    end else begin : g_wrap
      assign sum = full_sum[ACC_WIDTH-1:0];
    end
  endgenerate

endmodule : sat_adder
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : product_accumulator
// Purpose : Sums a last-delimited vector of unsigned products into a wider
//           accumulator and reports sum, term count and sticky overflow.
// Ports   : clk        in                   rising-edge clock
//           rst_n      in                   asynchronous active-low reset
//           clear      in                   synchronous abort of all state
//           in_valid   in                   product beat valid
//           in_ready   out                  beat can be accepted
//           in_product in  [PROD_WIDTH-1:0] unsigned product
//           in_last    in                   beat closes the vector
//           out_valid  out                  result valid
//           out_ready  in                   consumer takes result
//           out_sum    out [ACC_WIDTH-1:0]  accumulated sum
//           out_count  out [CNT_WIDTH-1:0]  term count (saturating)
//           out_ovf    out                  overflow seen in the vector
// Revision: 1.0 - initial release
// ============================================================================
module product_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_WIDTH = PROD_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int SATURATE   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_product,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_ovf
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  acc_state_e            state_q,     state_d;
  logic [ACC_WIDTH-1:0]  acc_q,       acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q,       cnt_d;
  logic                  ovf_q,       ovf_d;
  logic                  out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]  out_sum_q,   out_sum_d;
  logic [CNT_WIDTH-1:0]  out_count_q, out_count_d;
  logic                  out_ovf_q,   out_ovf_d;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic in_fire;
  logic out_fire;

  // A held result blocks input unless it is being taken this same cycle.
  assign in_ready = !out_valid_q | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

  // --------------------------------------------------------------------------
  // Datapath: running sum plus the incoming term
  // --------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_carry;

  assign addend = ACC_WIDTH'(in_product);

  sat_adder #(
    .ACC_WIDTH (ACC_WIDTH),
    .SATURATE  (SATURATE)
  ) u_sat_adder (
    .acc    (acc_q),
    .addend (addend),
    .sum    (add_sum),
    .carry  (add_carry)
  );

  // Values the vector takes once the current beat is folded in. A beat in
  // IDLE or DONE starts a fresh vector; only ACCUM continues one. In DONE a
  // beat is only accepted when the held result leaves in the same cycle.
  logic                 new_vector;
  logic [ACC_WIDTH-1:0] beat_acc;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic                 beat_ovf;

  always_comb begin
    new_vector = (state_q != ACCUM);
    if (new_vector) begin
      beat_acc = addend;
      beat_cnt = CNT_ONE;
      beat_ovf = 1'b0;
    end else begin
      beat_acc = add_sum;
      beat_cnt = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_ONE);
      beat_ovf = ovf_q | add_carry;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (clear) begin
      // Abort wins over everything, including a beat presented this cycle.
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (out_fire) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end

      if (in_fire) begin
        acc_d = beat_acc;
        cnt_d = beat_cnt;
        ovf_d = beat_ovf;
        if (in_last) begin
          out_sum_d   = beat_acc;
          out_count_d = beat_cnt;
          out_ovf_d   = beat_ovf;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = ACCUM;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule : product_accumulator
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_product_accumulator
// Purpose : Directed self-checking bench for product_accumulator. Three
//           instances share one stimulus: a 40-bit saturating unit, and
//           33-bit saturating and wrapping units for the overflow cases.
// Revision: 1.0 - initial release
// ============================================================================
module tb_product_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [31:0] in_product;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [39:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  logic        s_in_ready, s_out_valid, s_out_ovf;
  logic [32:0] s_out_sum;
  logic [7:0]  s_out_count;

  logic        w_in_ready, w_out_valid, w_out_ovf;
  logic [32:0] w_out_sum;
  logic [7:0]  w_out_count;

  int tests_run = 0;
  int tests_failed = 0;

  product_accumulator #(
    .PROD_WIDTH (32), .ACC_WIDTH (40), .CNT_WIDTH (8), .SATURATE (1)
  ) dut (
    .clk (clk), .rst_n (rst_n), .clear (clear),
    .in_valid (in_valid), .in_ready (in_ready), .in_product (in_product),
    .in_last (in_last), .out_valid (out_valid), .out_ready (out_ready),
    .out_sum (out_sum), .out_count (out_count), .out_ovf (out_ovf)
  );

  product_accumulator #(
    .PROD_WIDTH (32), .ACC_WIDTH (33), .CNT_WIDTH (8), .SATURATE (1)
  ) dut_sat33 (
    .clk (clk), .rst_n (rst_n), .clear (clear),
    .in_valid (in_valid), .in_ready (s_in_ready), .in_product (in_product),
    .in_last (in_last), .out_valid (s_out_valid), .out_ready (out_ready),
    .out_sum (s_out_sum), .out_count (s_out_count), .out_ovf (s_out_ovf)
  );

  product_accumulator #(
    .PROD_WIDTH (32), .ACC_WIDTH (33), .CNT_WIDTH (8), .SATURATE (0)
  ) dut_wrap33 (
    .clk (clk), .rst_n (rst_n), .clear (clear),
    .in_valid (in_valid), .in_ready (w_in_ready), .in_product (in_product),
    .in_last (in_last), .out_valid (w_out_valid), .out_ready (out_ready),
    .out_sum (w_out_sum), .out_count (w_out_count), .out_ovf (w_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] p, input logic last);
    in_valid   = 1'b1;
    in_product = p;
    in_last    = last;
    tick();
  endtask

  task automatic idle_in();
    in_valid   = 1'b0;
    in_product = 32'hDEAD_BEEF;
    in_last    = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    in_product = '0;
    in_last    = 1'b0;
    out_ready  = 1'b1;

    // ---------------- reset state ----------------
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum",   64'(out_sum),   64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_ovf",   64'(out_ovf),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    #9 rst_n = 1'b1;
    tick();

    // ---------------- 6 + 10 + 15 ----------------
    beat(32'd6, 1'b0);
    chk("v1_no_early_valid", 64'(out_valid), 64'd0);
    beat(32'd10, 1'b0);
    beat(32'd15, 1'b1);
    idle_in();
    chk("v1_valid", 64'(out_valid), 64'd1);
    chk("v1_sum",   64'(out_sum),   64'd31);
    chk("v1_count", 64'(out_count), 64'd3);
    chk("v1_ovf",   64'(out_ovf),   64'd0);
    tick();
    chk("v1_valid_drop", 64'(out_valid), 64'd0);

    // ---------------- single beat, max product ----------------
    beat(32'hFFFF_FFFF, 1'b1);
    idle_in();
    chk("v2_valid", 64'(out_valid), 64'd1);
    chk("v2_sum",   64'(out_sum),   64'h00_FFFF_FFFF);
    chk("v2_count", 64'(out_count), 64'd1);
    chk("v2_ovf",   64'(out_ovf),   64'd0);
    tick();

    // ---------------- three max products: wide, sat33, wrap33 ----------------
    beat(32'hFFFF_FFFF, 1'b0);
    beat(32'hFFFF_FFFF, 1'b0);
    beat(32'hFFFF_FFFF, 1'b1);
    idle_in();
    chk("v3_wide_sum",  64'(out_sum),     64'h2_FFFF_FFFD);
    chk("v3_wide_ovf",  64'(out_ovf),     64'd0);
    chk("v3_sat_valid", 64'(s_out_valid), 64'd1);
    chk("v3_sat_sum",   64'(s_out_sum),   64'h1_FFFF_FFFF);
    chk("v3_sat_ovf",   64'(s_out_ovf),   64'd1);
    chk("v3_sat_count", 64'(s_out_count), 64'd3);
    chk("v3_wrap_sum",  64'(w_out_sum),   64'h0_FFFF_FFFD);
    chk("v3_wrap_ovf",  64'(w_out_ovf),   64'd1);
    tick();

    // ---------------- backpressure hold, then same-cycle take + new beat ----------------
    out_ready = 1'b0;
    beat(32'd1, 1'b0);
    beat(32'd2, 1'b1);
    // A beat is offered throughout the hold; it must not be taken.
    in_valid   = 1'b1;
    in_product = 32'd50;
    in_last    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid",    64'(out_valid), 64'd1);
      chk("hold_sum",      64'(out_sum),   64'd3);
      chk("hold_count",    64'(out_count), 64'd2);
      chk("hold_in_ready", 64'(in_ready),  64'd0);
      tick();
    end
    out_ready  = 1'b1;
    in_product = 32'd7;
    in_last    = 1'b0;
    #1;
    chk("take_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("take_valid_drop", 64'(out_valid), 64'd0);
    beat(32'd2, 1'b1);
    idle_in();
    chk("v4_valid", 64'(out_valid), 64'd1);
    chk("v4_sum",   64'(out_sum),   64'd9);
    chk("v4_count", 64'(out_count), 64'd2);
    tick();

    // ---------------- clear mid-vector ----------------
    beat(32'd100, 1'b0);
    beat(32'd200, 1'b0);
    clear = 1'b1;
    beat(32'd1000, 1'b1);
    clear = 1'b0;
    chk("clr_no_valid", 64'(out_valid), 64'd0);
    beat(32'd4, 1'b0);
    chk("clr_no_valid2", 64'(out_valid), 64'd0);
    beat(32'd5, 1'b1);
    idle_in();
    chk("v5_valid", 64'(out_valid), 64'd1);
    chk("v5_sum",   64'(out_sum),   64'd9);
    chk("v5_count", 64'(out_count), 64'd2);
    chk("v5_ovf",   64'(out_ovf),   64'd0);
    tick();

    // ---------------- term counter saturation ----------------
    for (int i = 0; i < 299; i++) beat(32'd1, 1'b0);
    beat(32'd1, 1'b1);
    idle_in();
    chk("cntsat_count", 64'(out_count), 64'd255);
    chk("cntsat_sum",   64'(out_sum),   64'd300);
    tick();

    // ---------------- async reset mid-vector ----------------
    beat(32'd3, 1'b0);
    idle_in();
    #2 rst_n = 1'b0;
    #1;
    chk("arst1_valid", 64'(out_valid), 64'd0);
    chk("arst1_sum",   64'(out_sum),   64'd0);
    chk("arst1_count", 64'(out_count), 64'd0);
    #2 rst_n = 1'b1;
    tick();

    // ---------------- async reset while result held ----------------
    out_ready = 1'b0;
    beat(32'hFFFF_FFFF, 1'b0);
    beat(32'hFFFF_FFFF, 1'b0);
    beat(32'hFFFF_FFFF, 1'b1);
    idle_in();
    chk("arst2_pre_valid", 64'(s_out_valid), 64'd1);
    chk("arst2_pre_ovf",   64'(s_out_ovf),   64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst2_valid",     64'(out_valid),   64'd0);
    chk("arst2_sum",       64'(out_sum),     64'd0);
    chk("arst2_count",     64'(out_count),   64'd0);
    chk("arst2_sat_ovf",   64'(s_out_ovf),   64'd0);
    chk("arst2_sat_valid", 64'(s_out_valid), 64'd0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // ---------------- vector after reset ----------------
    beat(32'd3, 1'b0);
    beat(32'd3, 1'b1);
    idle_in();
    chk("v6_valid", 64'(out_valid), 64'd1);
    chk("v6_sum",   64'(out_sum),   64'd6);
    chk("v6_count", 64'(out_count), 64'd2);
    chk("v6_ovf",   64'(out_ovf),   64'd0);
    tick();
    chk("v6_valid_drop", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_product_accumulator
`default_nettype wire
